// File: rtl/bus85_arbiter.sv
// bus85_arbiter
// Shares the core85 multiplexed system bus between the processor and up to
// NREQ external bus masters using the 8085 HOLD/HLDA handshake. The arbiter
// raises hold, waits for hlda, then grants the bus to one requester chosen
// round-robin. Each tenure is capped at MAXHOLD clocks.
//
// Ports:
//   clk_i    system clock, all state changes on the rising edge
//   rst_ni   asynchronous active-low reset
//   req_i    per-master bus request (level, held for the whole tenure)
//   hlda_i   hold acknowledge from core85
//   hold_o   hold request to core85
//   gnt_o    one-hot bus grant, all-zero when no master owns the bus
//   owner_o  index of the current or most recent winner
//   tout_o   one-clock pulse when a tenure is ended by timeout
module bus85_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAXHOLD = 64,
  parameter int CNTSIZE = 8,
  parameter int OWNSIZE = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic               hlda_i,
  output logic               hold_o,
  output logic [NREQ-1:0]    gnt_o,
  output logic [OWNSIZE-1:0] owner_o,
  output logic               tout_o
);

  // Vectors are padded to the full range of an OWNSIZE-bit index so they can
  // be indexed by owner/scan values without out-of-range selects.
  localparam int NSLOT = 2 ** OWNSIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HREQ    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [OWNSIZE-1:0]   ptr_q, ptr_d;
  logic [CNTSIZE-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]      mask_q, mask_d;
  logic                 hold_q, hold_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [OWNSIZE-1:0]   owner_q, owner_d;
  logic                 tout_q, tout_d;

  logic [NSLOT-1:0]     elig_ext;
  logic [NSLOT-1:0]     req_ext;
  logic [NSLOT-1:0]     owner_onehot;
  logic                 win_found;
  logic [OWNSIZE-1:0]   win_idx;
  logic [OWNSIZE-1:0]   scan_idx;
  int                   scan_sum;
  logic                 owner_req;
  logic [OWNSIZE-1:0]   owner_next;

  assign elig_ext     = NSLOT'(req_i & ~mask_q);
  assign req_ext      = NSLOT'(req_i);
  assign owner_onehot = NSLOT'(1) << owner_q;
  assign owner_req    = req_ext[owner_q];
  assign owner_next   = (owner_q == OWNSIZE'(NREQ - 1)) ? '0 : owner_q + OWNSIZE'(1);

  // Round-robin pick: first eligible index starting at ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = 0;
    scan_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_sum = int'(ptr_q) + i;
      if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
      scan_idx = OWNSIZE'(scan_sum);
      if (!win_found && elig_ext[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output logic. A master's timeout mask is
  // forgotten on any edge where it is not requesting, so a master has to
  // drop its request at least once before it can win again.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q & req_i;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    tout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        hold_d = 1'b0;
        gnt_d  = '0;
        if (win_found) begin
          owner_d = win_idx;
          hold_d  = 1'b1;
          state_d = HREQ;
        end
      end

      HREQ: begin
        hold_d = 1'b1;
        gnt_d  = '0;
        if (!owner_req) begin
          hold_d  = 1'b0;
          state_d = RELEASE;
        end else if (hlda_i) begin
          gnt_d   = owner_onehot[NREQ-1:0];
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // Release causes are checked in priority order: owner drop, then
        // the core withdrawing hlda, then tenure timeout.
        if (!owner_req || !hlda_i) begin
          gnt_d   = '0;
          hold_d  = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == CNTSIZE'(MAXHOLD - 1)) begin
          gnt_d   = '0;
          hold_d  = 1'b0;
          tout_d  = 1'b1;
          mask_d  = (mask_q & req_i) | owner_onehot[NREQ-1:0];
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNTSIZE'(1);
        end
      end

      RELEASE: begin
        hold_d = 1'b0;
        gnt_d  = '0;
        if (!hlda_i) begin
          ptr_d   = owner_next;
          state_d = IDLE;
        end
      end

      default: begin
        hold_d  = 1'b0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops hold and gnt without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      hold_q  <= 1'b0;
      gnt_q   <= '0;
      owner_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      tout_q  <= tout_d;
    end
  end

  assign hold_o  = hold_q;
  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign tout_o  = tout_q;

endmodule

// File: tb/tb_bus85_arbiter.sv
// tb_bus85_arbiter
// Directed self-checking bench for bus85_arbiter (NREQ=4, MAXHOLD=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus85_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       hlda;
  logic       hold;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       tout;

  int checks = 0;
  int errors = 0;

  bus85_arbiter #(
    .NREQ(4), .MAXHOLD(8), .CNTSIZE(8), .OWNSIZE(2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .hlda_i (hlda),
    .hold_o (hold),
    .gnt_o  (gnt),
    .owner_o(owner),
    .tout_o (tout)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, let one rising edge pass, and return at the falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic h);
    req  = r;
    hlda = h;
    @(negedge clk);
  endtask

  // Compare every output against its expected value.
  task automatic checkOutput(input string tag, input logic eh, input logic [3:0] eg,
                             input logic [1:0] eo, input logic et);
    checks++;
    assert (hold === eh) else begin
      errors++;
      $error("[TB] FAIL %s hold: got %b expected %b", tag, hold, eh);
    end
    checks++;
    assert (gnt === eg) else begin
      errors++;
      $error("[TB] FAIL %s gnt: got %b expected %b", tag, gnt, eg);
    end
    checks++;
    assert (owner === eo) else begin
      errors++;
      $error("[TB] FAIL %s owner: got %0d expected %0d", tag, owner, eo);
    end
    checks++;
    assert (tout === et) else begin
      errors++;
      $error("[TB] FAIL %s tout: got %b expected %b", tag, tout, et);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req   = 4'b0000;
    hlda  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    hlda  = 1'b0;
    #2;
    checkOutput("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    applyReset();
    checkOutput("after_reset", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Single request, core acknowledges three clocks after hold.
    $display("[TB] single request");
    applyStimulus(4'b0001, 1'b0);
    checkOutput("single_hold", 1'b1, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("single_wait1", 1'b1, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("single_wait2", 1'b1, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_gnt", 1'b1, 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_gnt_hold", 1'b1, 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_release", 1'b0, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_rel_wait", 1'b0, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("single_idle", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Round robin with all four requesting; each tenure lasts 5 clocks.
    $display("[TB] round robin");
    applyReset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [1:0] who;
      logic [3:0] onehot;
      logic [3:0] dropped;
      who     = 2'(t % 4);
      onehot  = 4'b0001 << who;
      dropped = 4'b1111 & ~onehot;
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rr_hold", 1'b1, 4'b0000, who, 1'b0);
      for (int c = 0; c < 5; c++) begin
        applyStimulus(4'b1111, 1'b1);
        checkOutput("rr_gnt", 1'b1, onehot, who, 1'b0);
      end
      applyStimulus(dropped, 1'b1);
      checkOutput("rr_release", 1'b0, 4'b0000, who, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rr_idle", 1'b0, 4'b0000, who, 1'b0);
    end

    // Timeout: requester 1 holds its request past MAXHOLD.
    $display("[TB] timeout");
    applyReset();
    applyStimulus(4'b0010, 1'b0);
    checkOutput("to_hold", 1'b1, 4'b0000, 2'd1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0010, 1'b1);
      checkOutput("to_gnt", 1'b1, 4'b0010, 2'd1, 1'b0);
    end
    applyStimulus(4'b0010, 1'b1);
    checkOutput("to_pulse", 1'b0, 4'b0000, 2'd1, 1'b1);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("to_pulse_end", 1'b0, 4'b0000, 2'd1, 1'b0);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("to_next_owner", 1'b1, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("to_next_gnt", 1'b1, 4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("to_next_rel", 1'b0, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("to_idle", 1'b0, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("to_masked", 1'b0, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("to_unmask", 1'b0, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("to_regrant", 1'b1, 4'b0000, 2'd1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("to_abort", 1'b0, 4'b0000, 2'd1, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    // Abort in HREQ: requester 2 withdraws before hlda; ptr moves to 3.
    $display("[TB] abort");
    applyStimulus(4'b0100, 1'b0);
    checkOutput("ab_hold", 1'b1, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("ab_drop", 1'b0, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("ab_idle", 1'b0, 4'b0000, 2'd2, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("ab_ptr3", 1'b1, 4'b0000, 2'd3, 1'b0);

    // Forced release when the core withdraws hlda mid-grant.
    $display("[TB] forced release");
    applyStimulus(4'b1111, 1'b1);
    checkOutput("fr_gnt", 1'b1, 4'b1000, 2'd3, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("fr_release", 1'b0, 4'b0000, 2'd3, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("fr_idle", 1'b0, 4'b0000, 2'd3, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("fr_next", 1'b1, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("fr_next_gnt", 1'b1, 4'b0001, 2'd0, 1'b0);

    // Asynchronous reset in the middle of a grant, away from any edge.
    $display("[TB] async reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    req  = 4'b0000;
    hlda = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset", 1'b0, 4'b0000, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
